stream_pooling_n: RTL and testbench
===================================

STREAM_POOLING_N -- requirements
Module: stream_pooling_n

Interface
REQ-001 SHALL have parameter RESOLUTION, default 8, pixel width in bits.
REQ-002 SHALL have parameter N, default 2, square window side; power of two, >=2.
REQ-003 SHALL have parameter INPUT_SIDE, default 28, input frame side in pixels; divisible by N.
REQ-004 SHALL derive localparam OUTPUT_SIDE = INPUT_SIDE/N; it SHALL NOT be a free parameter.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-007 SHALL have port mode, input, 1, pooling mode: 0 = average, 1 = max.
REQ-008 SHALL have port in_valid, input, 1, input pixel valid.
REQ-009 SHALL have port in_ready, output, 1, block accepts an input pixel.
REQ-010 SHALL have port in_pixel, input, RESOLUTION, unsigned pixel, raster order, row-major.
REQ-011 SHALL have port out_valid, output, 1, pooled pixel valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the pooled pixel.
REQ-013 SHALL have port out_pixel, output, RESOLUTION, pooled pixel, raster order.
REQ-014 SHALL have port out_last, output, 1, qualifies the final pooled pixel of a frame.
REQ-015 SHALL have port busy, output, 1, high while a frame is in progress.

Function
REQ-016 An input transfer SHALL occur on a rising edge with in_valid && in_ready; an output transfer with out_valid && out_ready.
REQ-017 SHALL implement FSM states IDLE, RUN, FLUSH.
REQ-018 IDLE->RUN on the first input transfer; mode SHALL be sampled on that transfer and held for the whole frame.
REQ-019 RUN->FLUSH on the transfer of pixel INPUT_SIDE^2-1; FLUSH->IDLE on the output transfer with out_last=1.
REQ-020 SHALL track column (0..INPUT_SIDE-1) and row (0..INPUT_SIDE-1); column wraps to 0 and row increments after column INPUT_SIDE-1; both clear at frame end.
REQ-021 SHALL hold OUTPUT_SIDE accumulators of RESOLUTION+2*log2(N) bits, indexed column/N.
REQ-022 On the first pixel of a window (row%N==0 && column%N==0) the accumulator SHALL be loaded with the pixel; otherwise average mode adds and max mode keeps the unsigned maximum.
REQ-023 On the window-completing pixel (row%N==N-1 && column%N==N-1) the result SHALL be registered into the output register: average = (sum + pixel) >> 2*log2(N), floor truncation; max = max(acc, pixel).
REQ-024 out_valid SHALL assert the cycle after the completing input transfer (latency 1) and hold, with out_pixel and out_last stable, until out_ready.
REQ-025 in_ready SHALL be low when out_valid && !out_ready, and low in FLUSH; otherwise high.
REQ-026 A completing input and an output transfer in the same cycle SHALL both take effect, with no loss or duplication.
REQ-027 out_last SHALL be 1 only on pooled pixel OUTPUT_SIDE^2-1.
REQ-028 busy SHALL be 1 in RUN and FLUSH, 0 in IDLE.
REQ-029 Exactly OUTPUT_SIDE^2 output transfers SHALL occur per frame, in raster order.

Reset
REQ-030 On reset the FSM SHALL enter IDLE; counters, accumulators, and the latched mode SHALL be 0; outputs SHALL be out_valid=0, out_pixel=0, out_last=0, busy=0, in_ready=1.
REQ-031 Reset mid-frame SHALL discard the partial frame and any pending output; the next accepted pixel is pixel 0 of a new frame.

Structure
REQ-032 Package pooling_pkg SHALL hold the mode encodings (POOL_AVG=0, POOL_MAX=1), the FSM state typedef, and a clog2 constant function.
REQ-033 The accumulator array with its load/add/max update SHALL be sub-module pool_line_buffer.
REQ-034 Parameter legality (N power of two, INPUT_SIDE % N == 0) SHALL be checked at elaboration, with a fatal error in simulation.

Verification
REQ-035 Average ramp: defaults, pixel i = i mod 256, out_ready=1 -> first out_pixel 14 ((0+1+28+29)/4), 196 outputs, out_last on the 196th only.
REQ-036 Average constant: all pixels 3 -> every out_pixel 3; all pixels 255 -> every out_pixel 255 (no overflow).
REQ-037 Max ramp: mode=1, same ramp -> first out_pixel 29, second 31.
REQ-038 Backpressure: out_ready held low 5 cycles at the first output -> in_ready low the following cycle, out_pixel stable, no pixel lost; output sequence matches REQ-035.
REQ-039 Reset mid-frame: reset after pixel 300, then a constant-7 frame -> exactly 196 outputs, all 7, busy low before the first pixel.
REQ-040 Mode latch: mode toggled mid-frame after an average start -> all outputs of the frame are averages.

Source files
------------

// File: rtl/pooling_pkg.sv
// Shared types and helpers for the streaming N x N pooling block.
// Holds pooling mode encodings, FSM state type and a clog2 helper.
package pooling_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One accumulator per output column: load / add / max update plus result.
// Ports: clk, reset, en (update), first (load), mode, idx, pixel, result.
module pool_line_buffer
  import pooling_pkg::*;
#(
  parameter  int RESOLUTION = 8,
  parameter  int N          = 2,
  parameter  int DEPTH      = 14,
  localparam int LOG2N      = clog2(N),
  localparam int AW         = RESOLUTION + 2 * LOG2N,
  localparam int IW         = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  first,
  input  pool_mode_t            mode,
  input  logic [IW-1:0]         idx,
  input  logic [RESOLUTION-1:0] pixel,
  output logic [RESOLUTION-1:0] result
);

  logic [AW-1:0] acc [DEPTH];
  logic [AW-1:0] cur;
  logic [AW-1:0] ext;
  logic [AW-1:0] sum;
  logic [AW-1:0] big;
  logic [AW-1:0] avg;

  assign cur = acc[idx];
  assign ext = AW'(pixel);
  assign sum = cur + ext;
  assign big = (ext > cur) ? ext : cur;

  // Full window sum never exceeds AW bits, so the shift is exact floor.
  assign avg = sum >> (2 * LOG2N);

  always_comb begin
    result = '0;
    unique case (mode)
      POOL_AVG: result = RESOLUTION'(avg);
      POOL_MAX: result = RESOLUTION'(big);
      default:  result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        acc[i] <= '0;
    end else if (en) begin
      if (first)
        acc[idx] <= ext;
      else if (mode == POOL_AVG)
        acc[idx] <= sum;
      else
        acc[idx] <= big;
    end
  end

endmodule

// File: rtl/stream_pooling_n.sv
// Streaming N x N average/max pooling over a raster-ordered square frame.
// Ports: clk, reset, mode, in_valid/in_ready/in_pixel, out_valid/out_ready/out_pixel/out_last, busy.
module stream_pooling_n
  import pooling_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int N          = 2,
  parameter int INPUT_SIDE = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RESOLUTION-1:0] in_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RESOLUTION-1:0] out_pixel,
  output logic                  out_last,
  output logic                  busy
);

  localparam int OUTPUT_SIDE = INPUT_SIDE / N;
  localparam int LOG2N       = clog2(N);
  localparam int CW          = (clog2(INPUT_SIDE) < 1) ? 1 : clog2(INPUT_SIDE);
  localparam int IW          = (clog2(OUTPUT_SIDE) < 1) ? 1 : clog2(OUTPUT_SIDE);
  localparam logic [CW-1:0] LAST = CW'(INPUT_SIDE - 1);

  if (!((N >= 2) && ((N & (N - 1)) == 0) && (INPUT_SIDE % N == 0)))
  begin : g_bad_params
    $fatal(1, "stream_pooling_n: N must be a power of two >= 2 dividing INPUT_SIDE");
  end

  state_t                  state;
  pool_mode_t              mode_q;
  logic [CW-1:0]           col;
  logic [CW-1:0]           row;
  logic                    in_fire;
  logic                    out_fire;
  logic                    win_first;
  logic                    win_done;
  logic                    frame_end;
  pool_mode_t              eff_mode;
  logic [IW-1:0]           idx;
  logic [RESOLUTION-1:0]   lb_result;

  assign in_ready  = !(out_valid && !out_ready) && (state != FLUSH);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != IDLE);

  assign win_first = (row[LOG2N-1:0] == '0) && (col[LOG2N-1:0] == '0);
  assign win_done  = (&row[LOG2N-1:0]) && (&col[LOG2N-1:0]);
  assign frame_end = (row == LAST) && (col == LAST);
  assign idx       = IW'(col >> LOG2N);

  // The first pixel of a frame is processed with the live mode input.
  assign eff_mode  = (state == IDLE) ? pool_mode_t'(mode) : mode_q;

  pool_line_buffer #(
    .RESOLUTION (RESOLUTION),
    .N          (N),
    .DEPTH      (OUTPUT_SIDE)
  ) u_lb (
    .clk    (clk),
    .reset  (reset),
    .en     (in_fire),
    .first  (win_first),
    .mode   (eff_mode),
    .idx    (idx),
    .pixel  (in_pixel),
    .result (lb_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= POOL_AVG;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_fire)
        out_valid <= 1'b0;

      if (in_fire) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
        // A new result may overwrite only a slot being drained this cycle.
        if (win_done) begin
          out_valid <= 1'b1;
          out_pixel <= lb_result;
          out_last  <= frame_end;
        end
      end

      unique case (state)
        IDLE: begin
          if (in_fire) begin
            state  <= RUN;
            mode_q <= pool_mode_t'(mode);
          end
        end
        RUN: begin
          if (in_fire && frame_end)
            state <= FLUSH;
        end
        FLUSH: begin
          if (out_fire && out_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pooling_n.sv
// Self-checking bench for stream_pooling_n with a queue scoreboard.
// Covers reset, avg/max ramps, constants, backpressure, mid-frame reset, mode latch.
module tb_stream_pooling_n;

  localparam int RES   = 8;
  localparam int N     = 2;
  localparam int SIDE  = 28;
  localparam int OSIDE = SIDE / N;
  localparam int NPIX  = SIDE * SIDE;
  localparam int NOUT  = OSIDE * OSIDE;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           mode = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [RES-1:0] in_pixel = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [RES-1:0] out_pixel;
  logic           out_last;
  logic           busy;

  int             checks = 0;
  int             errors = 0;
  logic [RES:0]   sb[$];
  int             pix[NPIX];
  int             first_out;
  int             second_out;
  int             nout;

  always #5 clk = ~clk;

  stream_pooling_n #(
    .RESOLUTION (RES),
    .N          (N),
    .INPUT_SIDE (SIDE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++)
      pix[i] = i % 256;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NPIX; i++)
      pix[i] = v;
  endtask

  // Reference model: pooled frame pushed to the scoreboard in raster order.
  task automatic push_expect(input logic m);
    int s;
    int mx;
    int v;
    int r;
    for (int oy = 0; oy < OSIDE; oy++) begin
      for (int ox = 0; ox < OSIDE; ox++) begin
        s  = 0;
        mx = 0;
        for (int dy = 0; dy < N; dy++) begin
          for (int dx = 0; dx < N; dx++) begin
            v = pix[(oy * N + dy) * SIDE + ox * N + dx];
            s += v;
            if (v > mx) mx = v;
          end
        end
        r = m ? mx : s / (N * N);
        sb.push_back({(oy == OSIDE - 1 && ox == OSIDE - 1), 8'(r)});
      end
    end
  endtask

  task automatic run_frame(input logic m, input bit toggle, input bit bp,
                           input int limit);
    int           pi;
    int           cyc;
    int           stall;
    bit           bp_done;
    bit           busy_done;
    logic [RES-1:0] held;
    logic [RES:0] e;
    pi        = 0;
    cyc       = 0;
    stall     = 0;
    bp_done   = 0;
    busy_done = 0;
    held      = '0;
    nout      = 0;
    while ((pi < limit || (limit == NPIX && sb.size() > 0)) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      in_valid = (pi < limit);
      in_pixel = 8'(pix[(pi < NPIX) ? pi : 0]);
      mode     = (toggle && pi >= 50) ? ~m : m;
      if (bp && !bp_done && out_valid) begin
        stall   = 5;
        bp_done = 1;
        held    = out_pixel;
      end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_hold", out_pixel, held);
        stall--;
      end
      if (pi == 100 && !busy_done) begin
        check("busy_run", busy, 1);
        busy_done = 1;
      end
      if (in_valid && in_ready) pi++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("extra_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pixel", out_pixel, e[RES-1:0]);
          check("last", out_last, e[RES]);
        end
        if (nout == 0) first_out = out_pixel;
        if (nout == 1) second_out = out_pixel;
        nout++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 6000) check("timeout", cyc, 0);
    if (limit == NPIX) begin
      check("nout", nout, NOUT);
      @(negedge clk);
      #1;
      check("busy_idle", busy, 0);
      check("ready_idle", in_ready, 1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_pixel", out_pixel, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    fill_ramp();
    push_expect(1'b0);
    run_frame(1'b0, 0, 0, NPIX);
    check("avg_first", first_out, 14);

    fill_const(3);
    push_expect(1'b0);
    run_frame(1'b0, 0, 0, NPIX);

    fill_const(255);
    push_expect(1'b0);
    run_frame(1'b0, 0, 0, NPIX);

    fill_ramp();
    push_expect(1'b1);
    run_frame(1'b1, 0, 0, NPIX);
    check("max_first", first_out, 29);
    check("max_second", second_out, 31);

    fill_ramp();
    push_expect(1'b0);
    run_frame(1'b0, 0, 1, NPIX);
    check("bp_first", first_out, 14);

    fill_ramp();
    push_expect(1'b0);
    run_frame(1'b0, 0, 0, 301);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_busy_pre", busy, 0);
    check("mid_ready_pre", in_ready, 1);
    fill_const(7);
    push_expect(1'b0);
    run_frame(1'b0, 0, 0, NPIX);
    check("mid_first", first_out, 7);

    fill_ramp();
    push_expect(1'b0);
    run_frame(1'b0, 1, 0, NPIX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
